// File: rtl/mux_pkg.sv
// Shared constants and types for the rr_arb_mux output stage and its arbiter.
package mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   localparam int XFER_CNT_W = 16;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: searches req starting just after
// i_last_gnt, wrapping modulo NUM_CH.
module rr_arbiter #(
   parameter  int NUM_CH = 4,
   localparam int SEL_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] i_req,
   input  logic [SEL_W-1:0]  i_last_gnt,
   output logic              o_gnt_valid,
   output logic [SEL_W-1:0]  o_gnt
);

   always_comb begin
      // NOTE: every output gets a default before the search so no latch is inferred.
      o_gnt_valid = 1'b0;
      o_gnt       = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         int idx;
         idx = (int'(i_last_gnt) + k) % NUM_CH;
         if (!o_gnt_valid && i_req[idx]) begin
            o_gnt_valid = 1'b1;
            o_gnt       = SEL_W'(idx);
         end
      end
   end

endmodule

// File: rtl/rr_arb_mux.sv
// NUM_CH-to-1 valid/ready mux with a registered output stage, fixed-select or
// round-robin arbitration. Optional transfer counter: RR_ARB_MUX_XFER_CNT_EN.
module rr_arb_mux
   import mux_pkg::*;
#(
   parameter  int DATA_WIDTH = 4,
   parameter  int NUM_CH     = 4,
   localparam int SEL_W      = $clog2(NUM_CH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_mode,
   input  logic [SEL_W-1:0]             i_sel,
   input  logic [NUM_CH-1:0]            i_in_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] i_in_data,
   output logic [NUM_CH-1:0]            o_in_ready,
   output logic                         o_out_valid,
   output logic [DATA_WIDTH-1:0]        o_out_data,
   output logic [SEL_W-1:0]             o_out_ch,
   input  logic                         i_out_ready
`ifdef RR_ARB_MUX_XFER_CNT_EN
   ,
   output logic [XFER_CNT_W-1:0]        o_xfer_cnt
`endif
);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [SEL_W-1:0]        r_last_gnt;
   logic [DATA_WIDTH-1:0]   r_out_data;
   logic [SEL_W-1:0]        r_out_ch;

   logic                    w_load_en;
   logic                    w_rr_valid;
   logic [SEL_W-1:0]        w_rr_gnt;
   logic                    w_fix_valid;
   logic                    w_gnt_valid;
   logic [SEL_W-1:0]        w_gnt;
   logic                    w_xfer;
   logic [DATA_WIDTH-1:0]   w_sel_data;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .i_req       (i_in_valid),
      .i_last_gnt  (r_last_gnt),
      .o_gnt_valid (w_rr_valid),
      .o_gnt       (w_rr_gnt)
   );

   // A sel value beyond the last channel matches no bit and yields no grant.
   always_comb begin
      w_fix_valid = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (i_sel == SEL_W'(i) && i_in_valid[i]) w_fix_valid = 1'b1;
      end
   end

   always_comb begin
      if (i_mode == MODE_RR) begin
         w_gnt_valid = w_rr_valid;
         w_gnt       = w_rr_gnt;
      end else begin
         w_gnt_valid = w_fix_valid;
         w_gnt       = w_fix_valid ? i_sel : '0;
      end
   end

   assign w_load_en = (r_state == ST_EMPTY) | i_out_ready;
   assign w_xfer    = w_load_en & w_gnt_valid;

   always_comb begin
      o_in_ready = '0;
      w_sel_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_gnt == SEL_W'(i)) begin
            o_in_ready[i] = w_xfer;
            w_sel_data    = i_in_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) r_state <= ST_EMPTY;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
         ST_FULL:  if (i_out_ready && !w_xfer) w_state_nxt = ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   always_comb begin
      o_out_valid = (r_state == ST_FULL);
   end

   // Data and channel hold their last value when the register drains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_data <= '0;
         r_out_ch   <= '0;
         r_last_gnt <= SEL_W'(NUM_CH - 1);
      end else if (w_xfer) begin
         r_out_data <= w_sel_data;
         r_out_ch   <= w_gnt;
         r_last_gnt <= w_gnt;
      end
   end

   assign o_out_data = r_out_data;
   assign o_out_ch   = r_out_ch;

`ifdef RR_ARB_MUX_XFER_CNT_EN
   logic [XFER_CNT_W-1:0] r_xfer_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                           r_xfer_cnt <= '0;
      else if (o_out_valid && i_out_ready) r_xfer_cnt <= r_xfer_cnt + 1'b1;
   end

   assign o_xfer_cnt = r_xfer_cnt;
`else
   // Counter absent in this build.
`endif

endmodule
